// File: rtl/traffic_light_monitor_if.sv
// Lamp and status bundle between the light controller and its monitor.
// master drives the lamps and fault clear; slave is the monitor.
interface traffic_light_monitor_if;
  logic        red;
  logic        yellow;
  logic        green;
  logic        fault_clr;
  logic [1:0]  phase;
  logic        phase_change;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] cycle_count;

  modport master (
    output red, yellow, green, fault_clr,
    input  phase, phase_change, fault,
    input  fault_code, cycle_count
  );

  modport slave (
    input  red, yellow, green, fault_clr,
    output phase, phase_change, fault,
    output fault_code, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive lamp checker: one-hot, sequence and dwell checks.
// Dwell checks (codes 3/4) only with TL_DURATION_CHECK_EN defined.
module traffic_light_monitor #(
  parameter int RED    = 5,
  parameter int YELLOW = 3,
  parameter int GREEN  = 7,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  traffic_light_monitor_if.slave mon
);

  localparam logic [1:0] PH_N = 2'd0;
  localparam logic [1:0] PH_R = 2'd1;
  localparam logic [1:0] PH_G = 2'd2;
  localparam logic [1:0] PH_Y = 2'd3;

  localparam int MAXD =
    (RED > YELLOW) ? ((RED > GREEN) ? RED : GREEN)
                   : ((YELLOW > GREEN) ? YELLOW : GREEN);

  // Reject a dwell counter too narrow to reach max dwell + 1.
  if (CNT_W < $clog2(MAXD + 2)) begin : g_cnt_w_small
    $error("CNT_W too small for the configured dwells");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_GREEN,
    S_YELLOW,
    S_RESYNC
  } state_t;

  state_t state;

  logic       onehot;
  logic [1:0] lp;
  logic [1:0] cur;
  logic [1:0] nxt;
  logic       run;
  logic       hold;
  logic       adv;
  logic       f1;
  logic       f2;
  logic       f3;
  logic       f4;
  logic       flt;
  logic [2:0] code;

`ifdef TL_DURATION_CHECK_EN
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] exp_dw;
  logic             chk;
`endif

  function automatic state_t to_st(input logic [1:0] p);
    state_t s;
    unique case (p)
      PH_R:    s = S_RED;
      PH_G:    s = S_GREEN;
      PH_Y:    s = S_YELLOW;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

  // Decode lamps, classify this cycle and pick the fault code.
  always_comb begin
    onehot = $onehot({mon.red, mon.yellow, mon.green});
    lp = PH_N;
    if (onehot) begin
      unique case (1'b1)
        mon.red:    lp = PH_R;
        mon.green:  lp = PH_G;
        mon.yellow: lp = PH_Y;
        default:    lp = PH_N;
      endcase
    end
    cur = PH_N;
    run = 1'b0;
    unique case (state)
      S_RED: begin
        cur = PH_R;
        run = 1'b1;
      end
      S_GREEN: begin
        cur = PH_G;
        run = 1'b1;
      end
      S_YELLOW: begin
        cur = PH_Y;
        run = 1'b1;
      end
      default: ;
    endcase
    unique case (cur)
      PH_R:    nxt = PH_G;
      PH_G:    nxt = PH_Y;
      PH_Y:    nxt = PH_R;
      default: nxt = PH_N;
    endcase
    hold = run && onehot && (lp == cur);
    adv  = run && onehot && (lp == nxt);
    f1   = run && !onehot;
    f2   = run && onehot && !hold && !adv;
    f3   = 1'b0;
    f4   = 1'b0;
`ifdef TL_DURATION_CHECK_EN
    unique case (cur)
      PH_R:    exp_dw = CNT_W'(RED);
      PH_G:    exp_dw = CNT_W'(GREEN);
      PH_Y:    exp_dw = CNT_W'(YELLOW);
      default: exp_dw = '0;
    endcase
    f3 = adv && chk && (dwell < exp_dw);
    f4 = hold && chk && (dwell == exp_dw);
`endif
    flt = f1 | f2 | f3 | f4;
    unique case (1'b1)
      f1:      code = 3'd1;
      f2:      code = 3'd2;
      f3:      code = 3'd3;
      f4:      code = 3'd4;
      default: code = 3'd0;
    endcase
  end

  // Phase FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      mon.phase        <= PH_N;
      mon.phase_change <= 1'b0;
      mon.fault        <= 1'b0;
      mon.fault_code   <= 3'd0;
      mon.cycle_count  <= 16'd0;
`ifdef TL_DURATION_CHECK_EN
      dwell            <= '0;
      chk              <= 1'b0;
`endif
    end else begin
      mon.phase_change <= 1'b0;
      if (mon.fault_clr) begin
        mon.fault      <= 1'b0;
        mon.fault_code <= 3'd0;
      end
      if (flt) begin
        mon.fault <= 1'b1;
        if (mon.fault_clr || mon.fault_code == 3'd0)
          mon.fault_code <= code;
        state     <= S_RESYNC;
        mon.phase <= PH_N;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (onehot) begin
              state     <= to_st(lp);
              mon.phase <= lp;
`ifdef TL_DURATION_CHECK_EN
              dwell     <= CNT_W'(1);
              chk       <= 1'b0;
`endif
            end
          end
          S_RESYNC: begin
            if (onehot && mon.red) begin
              state     <= S_RED;
              mon.phase <= PH_R;
`ifdef TL_DURATION_CHECK_EN
              dwell     <= CNT_W'(1);
              chk       <= 1'b0;
`endif
            end
          end
          default: begin
            if (adv) begin
              state            <= to_st(nxt);
              mon.phase        <= nxt;
              mon.phase_change <= 1'b1;
              if (cur == PH_Y)
                mon.cycle_count <= mon.cycle_count + 16'd1;
`ifdef TL_DURATION_CHECK_EN
              dwell <= CNT_W'(1);
              chk   <= 1'b1;
            end else if (hold) begin
              if (dwell != '1)
                dwell <= dwell + 1'b1;
`endif
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table plus scoreboard.
// Expectations follow TL_DURATION_CHECK_EN when it is defined.
module tb_traffic_light_monitor;

`ifdef TL_DURATION_CHECK_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif

  localparam logic [2:0] L0  = 3'b000;
  localparam logic [2:0] LR  = 3'b100;
  localparam logic [2:0] LY  = 3'b010;
  localparam logic [2:0] LG  = 3'b001;
  localparam logic [2:0] LRG = 3'b101;

  typedef struct packed {
    logic [1:0]  ph;
    logic        pc;
    logic        f;
    logic [2:0]  code;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    logic       rs;
    logic       clr;
    logic [2:0] lamps;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vec_t tbl[$];
  out_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  traffic_light_monitor_if bus();

  traffic_light_monitor dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  always #5 clk = ~clk;

  task automatic add(
    input logic rs, input logic clr,
    input logic [2:0] l, input logic [1:0] ph,
    input logic pc, input logic f,
    input logic [2:0] code, input logic [15:0] cnt
  );
    vec_t v;
    v.rs    = rs;
    v.clr   = clr;
    v.lamps = l;
    v.exp   = '{ph: ph, pc: pc, f: f, code: code, cnt: cnt};
    tbl.push_back(v);
  endtask

  task automatic rep(
    input int n, input logic [2:0] l,
    input logic [1:0] ph, input logic f,
    input logic [2:0] code, input logic [15:0] cnt
  );
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, l, ph, 1'b0, f, code, cnt);
  endtask

  task automatic apply(input vec_t v);
    out_t got;
    out_t e;
    rst        = v.rs;
    bus.fault_clr = v.clr;
    bus.red    = v.lamps[2];
    bus.yellow = v.lamps[1];
    bus.green  = v.lamps[0];
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    got.ph   = bus.phase;
    got.pc   = bus.phase_change;
    got.f    = bus.fault;
    got.code = bus.fault_code;
    got.cnt  = bus.cycle_count;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL vec%0d scoreboard empty", n_vec);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL vec%0d got ph=%0d pc=%0b f=%0b code=%0d cnt=%0d exp ph=%0d pc=%0b f=%0b code=%0d cnt=%0d",
                 n_vec, got.ph, got.pc, got.f, got.code, got.cnt,
                 e.ph, e.pc, e.f, e.code, e.cnt);
      end
    end
  endtask

  task automatic hs(
    input logic rs, input logic [2:0] l,
    input logic [1:0] ph, input logic pc,
    input logic f, input logic [2:0] code,
    input logic [15:0] cnt
  );
    vec_t v;
    v.rs    = rs;
    v.clr   = 1'b0;
    v.lamps = l;
    v.exp   = '{ph: ph, pc: pc, f: f, code: code, cnt: cnt};
    apply(v);
  endtask

  initial begin
    bus.red       = 1'b0;
    bus.yellow    = 1'b0;
    bus.green     = 1'b0;
    bus.fault_clr = 1'b0;

    // reset state
    add(1, 0, L0, 0, 0, 0, 0, 0);
    // two legal rounds then red
    rep(5, LR, 1, 0, 0, 0);
    add(0, 0, LG, 2, 1, 0, 0, 0);
    rep(6, LG, 2, 0, 0, 0);
    add(0, 0, LY, 3, 1, 0, 0, 0);
    rep(2, LY, 3, 0, 0, 0);
    add(0, 0, LR, 1, 1, 0, 0, 1);
    rep(4, LR, 1, 0, 0, 1);
    add(0, 0, LG, 2, 1, 0, 0, 1);
    rep(6, LG, 2, 0, 0, 1);
    add(0, 0, LY, 3, 1, 0, 0, 1);
    rep(2, LY, 3, 0, 0, 1);
    add(0, 0, LR, 1, 1, 0, 0, 2);
    // short green
    rep(4, LR, 1, 0, 0, 2);
    add(0, 0, LG, 2, 1, 0, 0, 2);
    rep(5, LG, 2, 0, 0, 2);
    add(0, 0, LY, DUR ? 2'd0 : 2'd3, !DUR, DUR,
        DUR ? 3'd3 : 3'd0, 2);
    add(1, 0, L0, 0, 0, 0, 0, 0);
    // long green, then yellow ignored until red
    add(0, 0, LR, 1, 0, 0, 0, 0);
    add(0, 0, LG, 2, 1, 0, 0, 0);
    rep(6, LG, 2, 0, 0, 0);
    add(0, 0, LG, DUR ? 2'd0 : 2'd2, 0, DUR,
        DUR ? 3'd4 : 3'd0, 0);
    add(0, 0, LY, DUR ? 2'd0 : 2'd3, !DUR, DUR,
        DUR ? 3'd4 : 3'd0, 0);
    add(0, 0, LR, 1, !DUR, DUR,
        DUR ? 3'd4 : 3'd0, DUR ? 16'd0 : 16'd1);
    add(1, 0, L0, 0, 0, 0, 0, 0);
    // illegal transition, resync, clear, not one-hot
    add(0, 0, LR, 1, 0, 0, 0, 0);
    add(0, 0, LY, 0, 0, 1, 2, 0);
    add(0, 0, LRG, 0, 0, 1, 2, 0);
    add(0, 1, L0, 0, 0, 0, 0, 0);
    add(0, 0, LR, 1, 0, 0, 0, 0);
    add(0, 0, LRG, 0, 0, 1, 1, 0);
    add(0, 1, LR, 1, 0, 0, 0, 0);
    add(1, 0, L0, 0, 0, 0, 0, 0);
    // clear in the same cycle as a new short fault
    add(0, 0, LR, 1, 0, 0, 0, 0);
    add(0, 0, LY, 0, 0, 1, 2, 0);
    add(0, 0, LR, 1, 0, 1, 2, 0);
    add(0, 0, LG, 2, 1, 1, 2, 0);
    add(0, 1, LY, DUR ? 2'd0 : 2'd3, !DUR, DUR,
        DUR ? 3'd3 : 3'd0, 0);
    add(1, 0, L0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // IDLE ignores bad patterns; reset mid-green
    hs(0, L0, 0, 0, 0, 0, 0);
    hs(0, LRG, 0, 0, 0, 0, 0);
    hs(0, LR, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      hs(0, LR, 1, 0, 0, 0, 0);
    hs(0, LG, 2, 1, 0, 0, 0);
    hs(0, LG, 2, 0, 0, 0, 0);
    hs(1, LG, 0, 0, 0, 0, 0);
    hs(0, LR, 1, 0, 0, 0, 0);
    hs(0, LR, 1, 0, 0, 0, 0);
    hs(0, LG, 2, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      hs(0, LG, 2, 0, 0, 0, 0);
    hs(0, LY, 3, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
